// File: rtl/aes_v2_sub_seq.sv
// aes_v2_sub_seq: multi-cycle SubBytes, LANES shared sboxes stepped over four selected bytes
//   g_clk/g_reset : clock, synchronous active-high reset
//   valid,rs1,rs2 : request and operands (b0=rs1[7:0] b1=rs2[15:8] b2=rs1[23:16] b3=rs2[31:24])
//   enc, rot      : forward/inverse sbox select, rotated output order
//   ready, rd     : one-cycle completion pulse and result
//   Optional macro AES_V2_SUB_SEQ_CLEAR_EN: zero sbox inputs outside CALC, clear state on
//   completion/abort, and gate rd to zero while ready is low.
module aes_v2_sub_seq #(
    parameter int LANES = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] rd
);
    localparam int STEPS = 4 / LANES;
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("aes_v2_sub_seq: LANES must be 1, 2 or 4");
    end
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] res_q, res_d;
    logic [31:0] byt_q, byt_d;
    logic        enc_q, enc_d, rot_q, rot_d;
    logic [7:0]  sb_in [LANES];
    logic [7:0]  sb_out [LANES];
    logic [31:0] rd_ord;
    logic        last_step;
    logic        unused;
    assign unused = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};
    assign last_step = (step_q == 2'(STEPS - 1));
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] idx;
        assign idx = 2'(int'(step_q) * LANES + l);
`ifdef AES_V2_SUB_SEQ_CLEAR_EN
        assign sb_in[l] = (state_q == CALC) ? byt_q[idx*8 +: 8] : 8'h00;
`else
        assign sb_in[l] = byt_q[idx*8 +: 8];
`endif
        aes_sbox u_sbox (.x(sb_in[l]), .inv(!enc_q), .y(sb_out[l]));
    end
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            res_q   <= '0;
            byt_q   <= '0;
            enc_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            res_q   <= res_d;
            byt_q   <= byt_d;
            enc_q   <= enc_d;
            rot_q   <= rot_d;
        end
    end
    // Dropping valid mid-computation aborts; that check wins over the final step.
    always_comb begin
        state_d = (state_q == IDLE) ? (valid ? CALC : IDLE) :
                  (state_q == CALC) ? (!valid ? IDLE : (last_step ? DONE : CALC)) : IDLE;
    end
    always_comb begin
        step_d = step_q;
        res_d  = res_q;
        byt_d  = byt_q;
        enc_d  = enc_q;
        rot_d  = rot_q;
        if (state_q == IDLE && valid) begin
            byt_d  = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
            enc_d  = enc;
            rot_d  = rot;
            step_d = 2'd0;
        end else if (state_q == CALC && valid) begin
            for (int i = 0; i < LANES; i++)
                res_d[(int'(step_q) * LANES + i) * 8 +: 8] = sb_out[i];
            step_d = last_step ? step_q : step_q + 2'd1;
        end
`ifdef AES_V2_SUB_SEQ_CLEAR_EN
        if (state_q == DONE || (state_q == CALC && !valid)) begin
            res_d = '0;
            byt_d = '0;
        end
`endif
    end
    always_comb begin
        ready  = (state_q == DONE);
        rd_ord = rot_q ? {res_q[23:0], res_q[31:24]} : res_q;
`ifdef AES_V2_SUB_SEQ_CLEAR_EN
        rd     = ready ? rd_ord : 32'h0;
`else
        rd     = rd_ord;
`endif
    end
endmodule

// aes_sbox: combinational AES sbox (inv=1 selects inverse) via GF(2^8) inversion and affine map
module aes_sbox (
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction
    // a^254 is the multiplicative inverse, and maps 0 to 0 as the sbox requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, s);
            s = gmul(s, s);
        end
        return r;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction
    logic [7:0] fwd, pre;
    always_comb begin
        fwd = ginv(x);
        fwd = fwd ^ rotl(fwd, 1) ^ rotl(fwd, 2) ^ rotl(fwd, 3) ^ rotl(fwd, 4) ^ 8'h63;
        pre = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
        y   = inv ? ginv(pre) : fwd;
    end
endmodule

// File: doc/aes_v2_sub_seq.md
Name: aes_v2_sub_seq

Overview:
- Area-optimised, multi-cycle implementation of the lightweight AES SubBytes instruction. Same operand, result and control semantics as the single-cycle variant.
- Time-multiplexes LANES shared aes_sbox instances across the four selected bytes under a small FSM.
- Sits in the AES functional unit next to the latency-optimised variant. Selected at integration for low-area cores.

Parameters:
- LANES, 1, number of aes_sbox instances; legal values 1, 2, 4; other values are an elaboration error.

Ports:
- g_clk    input   1   clock; all state updates on rising edge
- g_reset  input   1   synchronous, active-high reset
- valid    input   1   request valid; held high with stable operands until ready
- rs1      input   32  source register 1
- rs2      input   32  source register 2
- enc      input   1   set: forward sbox; clear: inverse sbox
- rot      input   1   set: rotated output byte order
- ready    output  1   one-cycle pulse; rd valid this cycle
- rd       output  32  result

Behaviour:
- Byte selection:
  - b0 = rs1[7:0]
  - b1 = rs2[15:8]
  - b2 = rs1[23:16]
  - b3 = rs2[31:24]
- Result order, with s_k = sbox(b_k):
  - rot=0: {s3,s2,s1,s0}
  - rot=1: {s2,s1,s0,s3}
- States: IDLE, CALC, DONE.
- Step counter step, width 2, counts 0..STEPS-1, where STEPS = 4/LANES.
- IDLE:
  - On valid=1, latch the four selected bytes, enc and rot into internal registers.
  - step <= 0; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Lane l feeds byte index step*LANES+l from the latched bytes to its sbox, with inv = !latched_enc.
  - Sbox outputs are written into the 32-bit result register at the corresponding byte position (pre-rotation order).
  - When step == STEPS-1, go to DONE; otherwise step <= step+1.
- DONE:
  - ready=1 for exactly one cycle.
  - rd = result register, reordered per latched rot.
  - Next state is IDLE unconditionally.
- Latency: valid sampled in IDLE at cycle 0; ready at cycle STEPS+1.
  - LANES=1: ready at cycle 5
  - LANES=2: ready at cycle 3
  - LANES=4: ready at cycle 2
- Back-to-back operation:
  - If valid is still high in the cycle after ready, IDLE accepts it as a new request.
  - Minimum initiation interval is STEPS+2 cycles.
- Abort: valid=0 while in CALC returns the FSM to IDLE next cycle. No ready is issued; the partial result is discarded.
- Operands and enc/rot are used only from the latched copies. Changes during CALC (protocol violation) do not affect the result.
- ready is never asserted outside DONE. ready is never asserted in the same cycle valid is first sampled.
- Reset: g_reset=1 on any edge forces:
  - state = IDLE
  - step = 0
  - result register = 0
  - latched bytes = 0, latched enc = 0, latched rot = 0
  - ready = 0, rd = 0 from the following cycle
- Reset mid-CALC aborts with no ready.
- Reset has priority over all other transitions.
- The sbox instances are purely combinational; this block adds no pipeline register inside them.

Optional Feature:
- Macro: AES_V2_SUB_SEQ_CLEAR_EN.
- Defined:
  - Sbox inputs are forced to 0x00 whenever state != CALC.
  - The result register and latched bytes are cleared to 0 on the DONE->IDLE transition and on abort.
  - rd reads 0 whenever ready=0.
  - Purpose: operand/power hygiene.
- Undefined:
  - Sbox inputs follow the latched byte selected by step in all states.
  - The result register and latched bytes hold their values until overwritten.
  - rd always presents the reordered result register, including when ready=0.

Test Plan:
- LANES=1, enc=1, rot=0, rs1=0x00530001, rs2=0x00000000, valid held -> ready at cycle 5 only, rd=0x63ED637C.
- Same operands, rot=1 -> rd=0xED637C63; repeat with LANES=2 (ready cycle 3) and LANES=4 (ready cycle 2), identical rd.
- enc=0, rs1=0x00630063, rs2=0x63006300 -> rd=0x00000000; then rs1=0x0000007C, rs2=0 -> rd=0x52525201.
- Abort: start request, drop valid in second CALC cycle -> no ready pulse, FSM IDLE; next request completes with correct rd.
- Back-to-back: valid held continuously across two requests -> ready pulses separated by exactly STEPS+2 cycles, each rd correct.
- Reset: assert g_reset during CALC -> next cycle ready=0, rd=0, no ready for aborted op.
- With AES_V2_SUB_SEQ_CLEAR_EN: rd=0 whenever ready=0.
- Without AES_V2_SUB_SEQ_CLEAR_EN: rd holds the previous result after DONE.
